// File: rtl/vec3_normalize.sv
// rtl/vec3_normalize.sv - multi-cycle vec3 normaliser a/|a|; optional out_len port under VEC_NORM_LEN_OUT_EN
module vec3_normalize #(
    parameter int DATA_WIDTH = 32,
    parameter int FRAC_BITS  = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_WIDTH-1:0] in_x,
    input  logic [DATA_WIDTH-1:0] in_y,
    input  logic [DATA_WIDTH-1:0] in_z,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_x,
    output logic [DATA_WIDTH-1:0] out_y,
    output logic [DATA_WIDTH-1:0] out_z,
`ifdef VEC_NORM_LEN_OUT_EN
    output logic [DATA_WIDTH-1:0] out_len,
`endif
    output logic                  out_zero
);

    localparam int AW = 2 * DATA_WIDTH;          // sum-of-squares accumulator width
    localparam int QW = DATA_WIDTH + FRAC_BITS;  // divider dividend/quotient width
    localparam int RW = DATA_WIDTH + 4;          // signed sqrt partial remainder width
    localparam int CW = $clog2(QW) + 1;          // phase counter width
    localparam logic [QW-1:0]         Q_ONE = QW'(1) << FRAC_BITS;
    localparam logic [DATA_WIDTH-1:0] D_ONE = DATA_WIDTH'(1) << FRAC_BITS;

    typedef enum logic [2:0] {
        S_IDLE,
        S_SQ,
        S_SQRT,
        S_DIV,
        S_DONE
    } state_t;

    state_t                r_state;
    state_t                w_state_nxt;
    logic [CW-1:0]         r_cnt;

    logic [DATA_WIDTH-1:0] w_in      [3];
    logic [DATA_WIDTH-1:0] w_abs     [3];
    logic [DATA_WIDTH-1:0] r_mag     [3];
    logic [2:0]            r_sgn;

    logic [AW-1:0]         r_acc;
    logic [DATA_WIDTH-1:0] w_mag_sel;
    logic [AW-1:0]         w_mag_ext;
    logic [AW-1:0]         w_sq;

    logic signed [RW-1:0]  r_rem;
    logic signed [RW-1:0]  w_rem_sh;
    logic signed [RW-1:0]  w_rem_nxt;
    logic [DATA_WIDTH-1:0] r_root;
    logic [DATA_WIDTH-1:0] w_root_nxt;

    logic [QW-1:0]         r_dq       [3];
    logic [QW-1:0]         w_dq_nxt   [3];
    logic [DATA_WIDTH-1:0] r_drem     [3];
    logic [DATA_WIDTH-1:0] w_drem_nxt [3];
    logic [DATA_WIDTH:0]   w_trial    [3];
    logic [DATA_WIDTH-1:0] w_res      [3];
    logic                  w_len_zero;

    logic                  w_sq_last;
    logic                  w_sqrt_last;
    logic                  w_div_last;

    logic [DATA_WIDTH-1:0] r_out_x;
    logic [DATA_WIDTH-1:0] r_out_y;
    logic [DATA_WIDTH-1:0] r_out_z;
    logic                  r_out_zero;
`ifdef VEC_NORM_LEN_OUT_EN
    logic [DATA_WIDTH-1:0] r_out_len;
`endif

    assign w_in[0] = in_x;
    assign w_in[1] = in_y;
    assign w_in[2] = in_z;

    assign w_sq_last   = (r_cnt == CW'(2));
    assign w_sqrt_last = (r_cnt == CW'(DATA_WIDTH - 1));
    assign w_div_last  = (r_cnt == CW'(QW - 1));

    // Magnitudes as unsigned so the most-negative component maps to 2^(W-1) without wrapping
    always_comb begin
        for (int i = 0; i < 3; i++) begin
            w_abs[i] = w_in[i][DATA_WIDTH-1] ? -w_in[i] : w_in[i];
        end
    end

    // FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // FSM next-state and handshake outputs; each phase ends on a fixed count
    always_comb begin
        w_state_nxt = r_state;
        in_ready    = 1'b0;
        out_valid   = 1'b0;
        case (r_state)
            S_IDLE: begin
                in_ready = 1'b1;
                if (in_valid) w_state_nxt = S_SQ;
            end
            S_SQ:   if (w_sq_last)   w_state_nxt = S_SQRT;
            S_SQRT: if (w_sqrt_last) w_state_nxt = S_DIV;
            S_DIV:  if (w_div_last)  w_state_nxt = S_DONE;
            S_DONE: begin
                out_valid = 1'b1;
                if (out_ready) w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Phase counter: restarts on every state change, counts only in the compute phases
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (w_state_nxt != r_state) begin
            r_cnt <= '0;
        end else if (r_state == S_SQ || r_state == S_SQRT || r_state == S_DIV) begin
            r_cnt <= r_cnt + CW'(1);
        end
    end

    // One shared squarer, component selected by the SQ step count
    always_comb begin
        w_mag_sel = r_mag[0];
        case (r_cnt[1:0])
            2'd1:    w_mag_sel = r_mag[1];
            2'd2:    w_mag_sel = r_mag[2];
            default: w_mag_sel = r_mag[0];
        endcase
        w_mag_ext = AW'(w_mag_sel);
        w_sq      = w_mag_ext * w_mag_ext;
    end

    // Non-restoring sqrt step: bring down two radicand bits, add or subtract by remainder sign
    always_comb begin
        w_rem_sh = (r_rem <<< 2) + $signed({{(RW-2){1'b0}}, r_acc[AW-1:AW-2]});
        if (!w_rem_sh[RW-1]) begin
            w_rem_nxt = w_rem_sh - $signed({2'b00, r_root, 2'b01});
        end else begin
            w_rem_nxt = w_rem_sh + $signed({2'b00, r_root, 2'b11});
        end
        w_root_nxt = {r_root[DATA_WIDTH-2:0], ~w_rem_nxt[RW-1]};
    end

    // Three restoring divider steps by len, plus saturation, sign and zero handling of the final quotient
    always_comb begin
        w_len_zero = (r_root == '0);
        for (int i = 0; i < 3; i++) begin
            w_trial[i] = {r_drem[i], r_dq[i][QW-1]};
            if (w_trial[i] >= {1'b0, r_root}) begin
                w_drem_nxt[i] = DATA_WIDTH'(w_trial[i] - {1'b0, r_root});
                w_dq_nxt[i]   = {r_dq[i][QW-2:0], 1'b1};
            end else begin
                w_drem_nxt[i] = w_trial[i][DATA_WIDTH-1:0];
                w_dq_nxt[i]   = {r_dq[i][QW-2:0], 1'b0};
            end
            w_res[i] = (w_dq_nxt[i] > Q_ONE) ? D_ONE : w_dq_nxt[i][DATA_WIDTH-1:0];
            if (r_sgn[i])   w_res[i] = -w_res[i];
            if (w_len_zero) w_res[i] = '0;
        end
    end

    // Datapath: latch on accept, accumulate squares, iterate sqrt, iterate dividers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sgn  <= '0;
            r_acc  <= '0;
            r_rem  <= '0;
            r_root <= '0;
            for (int i = 0; i < 3; i++) begin
                r_mag[i]  <= '0;
                r_dq[i]   <= '0;
                r_drem[i] <= '0;
            end
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_acc  <= '0;
                    r_rem  <= '0;
                    r_root <= '0;
                    if (in_valid) begin
                        for (int i = 0; i < 3; i++) begin
                            r_mag[i]  <= w_abs[i];
                            r_sgn[i]  <= w_in[i][DATA_WIDTH-1];
                            r_dq[i]   <= {w_abs[i], {FRAC_BITS{1'b0}}};
                            r_drem[i] <= '0;
                        end
                    end
                end
                S_SQ: begin
                    r_acc <= r_acc + w_sq;
                end
                S_SQRT: begin
                    r_rem  <= w_rem_nxt;
                    r_root <= w_root_nxt;
                    r_acc  <= {r_acc[AW-3:0], 2'b00};
                end
                S_DIV: begin
                    for (int i = 0; i < 3; i++) begin
                        r_dq[i]   <= w_dq_nxt[i];
                        r_drem[i] <= w_drem_nxt[i];
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // Result registers load on the last divide step and hold through DONE
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out_x    <= '0;
            r_out_y    <= '0;
            r_out_z    <= '0;
            r_out_zero <= 1'b0;
`ifdef VEC_NORM_LEN_OUT_EN
            r_out_len  <= '0;
`endif
        end else if (r_state == S_DIV && w_div_last) begin
            r_out_x    <= w_res[0];
            r_out_y    <= w_res[1];
            r_out_z    <= w_res[2];
            r_out_zero <= w_len_zero;
`ifdef VEC_NORM_LEN_OUT_EN
            r_out_len  <= r_root;
`endif
        end
    end

    assign out_x    = r_out_x;
    assign out_y    = r_out_y;
    assign out_z    = r_out_z;
    assign out_zero = r_out_zero;
`ifdef VEC_NORM_LEN_OUT_EN
    assign out_len  = r_out_len;
`endif

endmodule

// File: tb/tb_vec3_normalize.sv
// tb/tb_vec3_normalize.sv - directed self-checking bench for vec3_normalize
module tb_vec3_normalize;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_x;
    logic [31:0] in_y;
    logic [31:0] in_z;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_x;
    logic [31:0] out_y;
    logic [31:0] out_z;
    logic        out_zero;
`ifdef VEC_NORM_LEN_OUT_EN
    logic [31:0] out_len;
`endif

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    vec3_normalize #(
        .DATA_WIDTH(32),
        .FRAC_BITS (16)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_x     (in_x),
        .in_y     (in_y),
        .in_z     (in_z),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_x    (out_x),
        .out_y    (out_y),
        .out_z    (out_z),
`ifdef VEC_NORM_LEN_OUT_EN
        .out_len  (out_len),
`endif
        .out_zero (out_zero)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Accept one vector and wait for out_valid; optionally toggles in_valid with junk while busy
    task automatic send(input string tag, input logic [31:0] x, input logic [31:0] y,
                        input logic [31:0] z, input bit noise);
        int lat;
        check({tag, "/in_ready_idle"}, 32'(in_ready), 32'd1);
        in_x     = x;
        in_y     = y;
        in_z     = z;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = noise;
        if (noise) begin
            in_x = 32'h1234_5678;
            in_y = 32'h8000_0000;
            in_z = 32'h0007_0000;
        end
        lat = 0;
        while (!out_valid && lat < 200) begin
            @(posedge clk);
            #1;
            lat++;
            if (lat == 20) in_valid = 1'b0;
        end
        in_valid = 1'b0;
        check({tag, "/latency"}, 32'(lat), 32'd83);
    endtask

    task automatic expect_out(input string tag, input logic [31:0] ex, input logic [31:0] ey,
                              input logic [31:0] ez, input logic ezero, input logic [31:0] elen);
        check({tag, "/out_x"}, out_x, ex);
        check({tag, "/out_y"}, out_y, ey);
        check({tag, "/out_z"}, out_z, ez);
        check({tag, "/out_zero"}, 32'(out_zero), 32'(ezero));
        check({tag, "/in_ready_done"}, 32'(in_ready), 32'd0);
`ifdef VEC_NORM_LEN_OUT_EN
        check({tag, "/out_len"}, out_len, elen);
`else
        if (elen === 32'hxxxx_xxxx) $display("note: %s len unknown", tag);
`endif
    endtask

    task automatic release_out(input string tag);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        check({tag, "/in_ready_after"}, 32'(in_ready), 32'd1);
        check({tag, "/out_valid_after"}, 32'(out_valid), 32'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        in_x      = '0;
        in_y      = '0;
        in_z      = '0;
        repeat (3) @(posedge clk);
        #1;
        check("reset/in_ready", 32'(in_ready), 32'd1);
        check("reset/out_valid", 32'(out_valid), 32'd0);
        check("reset/out_x", out_x, 32'd0);
        check("reset/out_zero", 32'(out_zero), 32'd0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // unit x axis
        send("unit_x", 32'h0001_0000, 32'h0, 32'h0, 1'b0);
        expect_out("unit_x", 32'h0001_0000, 32'h0, 32'h0, 1'b0, 32'h0001_0000);
        release_out("unit_x");

        // 3-4-5 with backpressure held for 10 cycles
        send("v345", 32'h0003_0000, 32'h0004_0000, 32'h0, 1'b0);
        expect_out("v345", 32'h0000_9999, 32'h0000_CCCC, 32'h0, 1'b0, 32'h0005_0000);
        repeat (10) @(posedge clk);
        #1;
        check("bp/out_valid", 32'(out_valid), 32'd1);
        check("bp/in_ready", 32'(in_ready), 32'd0);
        check("bp/out_x", out_x, 32'h0000_9999);
        check("bp/out_y", out_y, 32'h0000_CCCC);
        release_out("v345");

        // negative component, immediately after backpressure release
        send("neg", 32'hFFFD_0000, 32'h0, 32'h0004_0000, 1'b0);
        expect_out("neg", 32'hFFFF_6667, 32'h0, 32'h0000_CCCC, 1'b0, 32'h0005_0000);
        release_out("neg");

        // zero vector
        send("zero", 32'h0, 32'h0, 32'h0, 1'b0);
        expect_out("zero", 32'h0, 32'h0, 32'h0, 1'b1, 32'h0);
        release_out("zero");

        // most-negative component
        send("minneg", 32'h8000_0000, 32'h0, 32'h0, 1'b0);
        expect_out("minneg", 32'hFFFF_0000, 32'h0, 32'h0, 1'b0, 32'h8000_0000);
        release_out("minneg");

        // tiny vector: floor sqrt gives len=1, quotient lands exactly on 1.0
        send("tiny", 32'h1, 32'h1, 32'h1, 1'b0);
        expect_out("tiny", 32'h0001_0000, 32'h0001_0000, 32'h0001_0000, 1'b0, 32'h1);
        release_out("tiny");

        // in_valid asserted with junk while busy must be ignored
        send("busy", 32'h0, 32'h0, 32'hFFFF_0000, 1'b1);
        expect_out("busy", 32'h0, 32'h0, 32'hFFFF_0000, 1'b0, 32'h0001_0000);
        release_out("busy");

        // async reset in the middle of SQRT
        in_x     = 32'h0001_0000;
        in_y     = 32'h0001_0000;
        in_z     = 32'h0;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (13) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("midrst/out_valid", 32'(out_valid), 32'd0);
        check("midrst/out_z", out_z, 32'd0);
        check("midrst/out_zero", 32'(out_zero), 32'd0);
        check("midrst/in_ready", 32'(in_ready), 32'd1);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        send("post_rst", 32'h0, 32'h0003_0000, 32'h0004_0000, 1'b0);
        expect_out("post_rst", 32'h0, 32'h0000_9999, 32'h0000_CCCC, 1'b0, 32'h0005_0000);
        release_out("post_rst");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
